// File: rtl/npc_pc_unit_pkg.sv
// Shared NPCOp encodings and datapath widths for the fetch-stage next-PC logic.
package npc_pc_unit_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned IMM16_W = 16;
    localparam int unsigned IMM26_W = 26;
    localparam int unsigned NPCOP_W = 2;

    // NPCOp codes produced by the ID-stage NPCOp generator
    typedef enum logic [NPCOP_W-1:0] {
        NPC_PLUS4    = 2'b00,
        NPC_BRANCH   = 2'b01,
        NPC_JUMP_IMM = 2'b10,
        NPC_JUMP_REG = 2'b11
    } npcop_e;

endpackage

// File: rtl/npc_pc_unit_target_calc.sv
// Redirect target computation for the ID-stage instruction; purely combinational.
module npc_target_calc
    import npc_pc_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] TRAP_PC = 32'h0000_4180
) (
    input  npcop_e             npcop,
    input  logic [XLEN-1:0]    id_pc_plus4,
    input  logic [IMM16_W-1:0] imm16,
    input  logic [IMM26_W-1:0] imm26,
    input  logic [XLEN-1:0]    rs_data,
    output logic [XLEN-1:0]    target,
    output logic               misaligned
);

    logic [XLEN-1:0] br_offset;

    // Sign-extended word offset for branches
    assign br_offset = {{(XLEN-IMM16_W-2){imm16[IMM16_W-1]}}, imm16, 2'b00};

    // Select the target by NPCOp; a misaligned register target vectors to the trap address
    always_comb begin
        target     = id_pc_plus4;
        misaligned = 1'b0;
        case (npcop)
            NPC_BRANCH:   target = id_pc_plus4 + br_offset;
            NPC_JUMP_IMM: target = {id_pc_plus4[XLEN-1:XLEN-4], imm26, 2'b00};
            NPC_JUMP_REG: begin
                misaligned = (rs_data[1:0] != 2'b00);
                target     = misaligned ? TRAP_PC : rs_data;
            end
            default:      target = id_pc_plus4;
        endcase
    end

endmodule

// File: rtl/npc_pc_unit.sv
// Fetch-stage PC register with next-PC selection, stall hold and pending-redirect capture.
module npc_pc_unit
    import npc_pc_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_3000,
    parameter logic [XLEN-1:0] TRAP_PC  = 32'h0000_4180
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               imem_ready,
    input  logic               id_valid,
    input  logic [NPCOP_W-1:0] id_npcop,
    input  logic [XLEN-1:0]    id_pc_plus4,
    input  logic [IMM16_W-1:0] id_imm16,
    input  logic [IMM26_W-1:0] id_imm26,
    input  logic [XLEN-1:0]    id_rs_data,
    output logic [XLEN-1:0]    pc,
    output logic [XLEN-1:0]    pc_plus4,
    output logic               fetch_valid,
    output logic               flush,
    output logic               addr_err
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_target_q, pend_target_d;
    logic            pend_valid_q, pend_valid_d;
    logic            addr_err_q, addr_err_d;
    logic [XLEN-1:0] target;
    logic            misaligned;
    logic            redirect;
    npcop_e          npcop;

    assign npcop = npcop_e'(id_npcop);

    npc_target_calc #(
        .TRAP_PC (TRAP_PC)
    ) u_target_calc (
        .npcop       (npcop),
        .id_pc_plus4 (id_pc_plus4),
        .imm16       (id_imm16),
        .imm26       (id_imm26),
        .rs_data     (id_rs_data),
        .target      (target),
        .misaligned  (misaligned)
    );

    // A real, non-stalled ID instruction asking for a non-sequential PC
    assign redirect    = id_valid && (npcop != NPC_PLUS4) && !stall;
    assign flush       = redirect;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + XLEN'(4);
    assign fetch_valid = imem_ready && !pend_valid_q;
    assign addr_err    = addr_err_q;

    // Next-state selection: stall, then fresh redirect, then pending redirect, then sequential
    always_comb begin
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        addr_err_d    = addr_err_q;
        if (stall) begin
            pc_d = pc_q;
        end else if (redirect) begin
            addr_err_d = addr_err_q | misaligned;
            if (imem_ready) begin
                pc_d         = target;
                pend_valid_d = 1'b0;
            end else begin
                pend_target_d = target;
                pend_valid_d  = 1'b1;
            end
        end else if (pend_valid_q && imem_ready) begin
            pc_d         = pend_target_q;
            pend_valid_d = 1'b0;
        end else if (imem_ready) begin
            pc_d = pc_plus4;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
            addr_err_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            addr_err_q    <= addr_err_d;
        end
    end

endmodule

// File: tb/tb_npc_pc_unit.sv
// Bench for npc_pc_unit: expected PCs are queued as stimulus is applied and checked after each edge.
module tb_npc_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        imem_ready;
    logic        id_valid;
    logic [1:0]  id_npcop;
    logic [31:0] id_pc_plus4;
    logic [15:0] id_imm16;
    logic [25:0] id_imm26;
    logic [31:0] id_rs_data;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        flush;
    logic        addr_err;

    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;
    int          vectors     = 0;
    int          miscompares = 0;

    npc_pc_unit dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .imem_ready  (imem_ready),
        .id_valid    (id_valid),
        .id_npcop    (id_npcop),
        .id_pc_plus4 (id_pc_plus4),
        .id_imm16    (id_imm16),
        .id_imm26    (id_imm26),
        .id_rs_data  (id_rs_data),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .fetch_valid (fetch_valid),
        .flush       (flush),
        .addr_err    (addr_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [1:0] op, input logic [31:0] p4,
                          input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] rs);
        id_valid    = v;
        id_npcop    = op;
        id_pc_plus4 = p4;
        id_imm16    = i16;
        id_imm26    = i26;
        id_rs_data  = rs;
    endtask

    task automatic idle();
        set_id(1'b0, 2'b00, 32'h0, 16'h0, 26'h0, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall = 1'b0;
        imem_ready = 1'b0;
        idle();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors++;
        if (pc !== 32'h0000_3000) begin
            miscompares++;
            $display("FAIL reset_pc: got %h want %h", pc, 32'h0000_3000);
        end
        vectors++;
        if (addr_err !== 1'b0 || flush !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: addr_err=%b flush=%b want 0/0", addr_err, flush);
        end
        imem_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(32'h0000_3000 + 32'(4 * i));
            tick();
            exp_pc = exp_q.pop_front();
            vectors++;
            if (pc !== exp_pc || flush !== 1'b0) begin
                miscompares++;
                $display("FAIL seq_step%0d: pc=%h flush=%b want %h/0", i, pc, flush, exp_pc);
            end
        end
    endtask

    task automatic test_branch();
        imem_ready = 1'b1;
        set_id(1'b1, 2'b01, 32'h0000_3008, 16'hFFFE, 26'h0, 32'h0);
        exp_q.push_back(32'h0000_3000);
        #1;
        vectors++;
        if (flush !== 1'b1) begin
            miscompares++;
            $display("FAIL branch_flush: got %b want 1", flush);
        end
        tick();
        idle();
        exp_pc = exp_q.pop_front();
        vectors++;
        if (pc !== exp_pc) begin
            miscompares++;
            $display("FAIL branch_pc: got %h want %h", pc, exp_pc);
        end
    endtask

    task automatic test_jump_imm();
        imem_ready = 1'b1;
        set_id(1'b1, 2'b10, 32'h0000_3010, 16'h0, 26'h000_0C10, 32'h0);
        exp_q.push_back(32'h0000_3040);
        tick();
        idle();
        exp_pc = exp_q.pop_front();
        vectors++;
        if (pc !== exp_pc) begin
            miscompares++;
            $display("FAIL jump_imm_pc: got %h want %h", pc, exp_pc);
        end
    endtask

    task automatic test_jump_reg_err();
        imem_ready = 1'b1;
        set_id(1'b1, 2'b11, 32'h0000_3044, 16'h0, 26'h0, 32'h0000_3041);
        exp_q.push_back(32'h0000_4180);
        tick();
        idle();
        exp_pc = exp_q.pop_front();
        vectors++;
        if (pc !== exp_pc || addr_err !== 1'b1) begin
            miscompares++;
            $display("FAIL jump_reg_trap: pc=%h addr_err=%b want %h/1", pc, addr_err, exp_pc);
        end
        for (int i = 1; i <= 10; i++) begin
            exp_q.push_back(32'h0000_4180 + 32'(4 * i));
            tick();
            exp_pc = exp_q.pop_front();
            vectors++;
            if (pc !== exp_pc || addr_err !== 1'b1) begin
                miscompares++;
                $display("FAIL addr_err_sticky%0d: pc=%h addr_err=%b want %h/1", i, pc, addr_err, exp_pc);
            end
        end
        do_reset();
        vectors++;
        if (addr_err !== 1'b0 || pc !== 32'h0000_3000) begin
            miscompares++;
            $display("FAIL addr_err_clear: addr_err=%b pc=%h want 0/00003000", addr_err, pc);
        end
    endtask

    task automatic test_pending();
        do_reset();
        // branch to 0x3100 while memory is busy
        imem_ready = 1'b0;
        set_id(1'b1, 2'b01, 32'h0000_3000, 16'h0040, 26'h0, 32'h0);
        exp_q.push_back(32'h0000_3000);
        #1;
        vectors++;
        if (flush !== 1'b1) begin
            miscompares++;
            $display("FAIL pend_flush: got %b want 1", flush);
        end
        tick();
        idle();
        exp_q.push_back(32'h0000_3000);
        for (int i = 0; i < 2; i++) begin
            exp_pc = exp_q.pop_front();
            vectors++;
            if (pc !== exp_pc || fetch_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL pend_hold%0d: pc=%h fetch_valid=%b want %h/0", i, pc, fetch_valid, exp_pc);
            end
            if (i == 0) tick();
        end
        imem_ready = 1'b1;
        #1;
        vectors++;
        if (fetch_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL pend_fetch_valid: got %b want 0", fetch_valid);
        end
        exp_q.push_back(32'h0000_3100);
        tick();
        exp_pc = exp_q.pop_front();
        vectors++;
        if (pc !== exp_pc || fetch_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pend_land: pc=%h fetch_valid=%b want %h/1", pc, fetch_valid, exp_pc);
        end
        // two redirects while pending: the later one wins
        imem_ready = 1'b0;
        set_id(1'b1, 2'b01, 32'h0000_3000, 16'h0040, 26'h0, 32'h0);
        tick();
        set_id(1'b1, 2'b01, 32'h0000_3000, 16'h0080, 26'h0, 32'h0);
        tick();
        idle();
        imem_ready = 1'b1;
        exp_q.push_back(32'h0000_3200);
        tick();
        exp_pc = exp_q.pop_front();
        vectors++;
        if (pc !== exp_pc) begin
            miscompares++;
            $display("FAIL pend_last_wins: got %h want %h", pc, exp_pc);
        end
    endtask

    task automatic test_stall();
        imem_ready = 1'b1;
        stall = 1'b1;
        set_id(1'b1, 2'b01, 32'h0000_3200, 16'h0010, 26'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'h0000_3200);
            #1;
            vectors++;
            if (flush !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_flush%0d: got %b want 0", i, flush);
            end
            tick();
            exp_pc = exp_q.pop_front();
            vectors++;
            if (pc !== exp_pc) begin
                miscompares++;
                $display("FAIL stall_pc%0d: got %h want %h", i, pc, exp_pc);
            end
        end
        stall = 1'b0;
        #1;
        vectors++;
        if (flush !== 1'b1) begin
            miscompares++;
            $display("FAIL unstall_flush: got %b want 1", flush);
        end
        exp_q.push_back(32'h0000_3240);
        tick();
        idle();
        exp_pc = exp_q.pop_front();
        vectors++;
        if (pc !== exp_pc) begin
            miscompares++;
            $display("FAIL unstall_pc: got %h want %h", pc, exp_pc);
        end
    endtask

    task automatic test_rst_pending();
        imem_ready = 1'b0;
        set_id(1'b1, 2'b10, 32'h0000_3000, 16'h0, 26'h000_0800, 32'h0);
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (pc !== 32'h0000_3000) begin
            miscompares++;
            $display("FAIL rst_pend_pc: got %h want %h", pc, 32'h0000_3000);
        end
        imem_ready = 1'b1;
        exp_q.push_back(32'h0000_3004);
        tick();
        exp_pc = exp_q.pop_front();
        vectors++;
        if (pc !== exp_pc) begin
            miscompares++;
            $display("FAIL rst_pend_discard: got %h want %h", pc, exp_pc);
        end
    endtask

    task automatic test_bubble_and_wrap();
        imem_ready = 1'b1;
        set_id(1'b0, 2'b01, 32'h0000_3000, 16'h0100, 26'h0, 32'h0);
        #1;
        vectors++;
        if (flush !== 1'b0) begin
            miscompares++;
            $display("FAIL bubble_flush: got %b want 0", flush);
        end
        exp_q.push_back(32'h0000_3008);
        tick();
        exp_pc = exp_q.pop_front();
        vectors++;
        if (pc !== exp_pc) begin
            miscompares++;
            $display("FAIL bubble_pc: got %h want %h", pc, exp_pc);
        end
        set_id(1'b1, 2'b11, 32'h0000_300C, 16'h0, 26'h0, 32'hFFFF_FFFC);
        exp_q.push_back(32'hFFFF_FFFC);
        tick();
        idle();
        exp_pc = exp_q.pop_front();
        vectors++;
        if (pc !== exp_pc || pc_plus4 !== 32'h0 || addr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_setup: pc=%h pc_plus4=%h addr_err=%b want %h/0/0", pc, pc_plus4, addr_err, exp_pc);
        end
        exp_q.push_back(32'h0000_0000);
        tick();
        exp_pc = exp_q.pop_front();
        vectors++;
        if (pc !== exp_pc) begin
            miscompares++;
            $display("FAIL wrap_pc: got %h want %h", pc, exp_pc);
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_jump_imm();
        test_jump_reg_err();
        test_pending();
        test_stall();
        test_rst_pending();
        test_bubble_and_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
